// File: rtl/ef_apb_wb_irq_bridge_if.sv
// ----------------------------------------------------------------------------
// ef_apb_wb_irq_bridge_if
// APB3 slave-side bundle used by the APB-to-Wishbone/IRQ bridge.
//   psel, penable, pwrite : APB control (master -> slave)
//   paddr, pwdata         : 32-bit byte address / write data (master -> slave)
//   prdata                : 32-bit read data (slave -> master)
//   pready, pslverr       : completion pulse and error flag (slave -> master)
// ----------------------------------------------------------------------------
interface ef_apb_wb_irq_bridge_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/ef_apb_wb_irq_bridge.sv
// ----------------------------------------------------------------------------
// ef_apb_wb_irq_bridge
// APB slave that forwards accesses outside the local register page to a
// Wishbone core (with a bounded wait) and hosts an IM/MIS/RIS/ICR interrupt
// block for NUM_IRQ sources, each level or rising-edge sticky.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   apb             : APB slave bundle (prdata/pready/pslverr registered)
//   wb_cyc_o/stb_o  : Wishbone cycle/strobe (registered, always equal)
//   wb_we_o         : Wishbone write enable
//   wb_adr_o        : Wishbone word address
//   wb_dat_o        : Wishbone write data
//   wb_sel_o        : Wishbone byte selects (all ones)
//   wb_dat_i        : Wishbone read data
//   wb_ack_i        : Wishbone acknowledge
//   irq_src_i       : raw interrupt sources
//   irq_o           : registered OR of masked interrupt status
// ----------------------------------------------------------------------------
module ef_apb_wb_irq_bridge #(
  parameter int unsigned NUM_IRQ        = 9,
  parameter logic [31:0] IRQ_EDGE_MASK  = 32'h0,
  parameter int unsigned WB_DW          = 16,
  parameter int unsigned WB_AW          = 3,
  parameter logic [7:0]  REG_PAGE       = 8'h0F,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  ef_apb_wb_irq_bridge_if.slave apb,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o,
  output logic [WB_AW-1:0]     wb_adr_o,
  output logic [WB_DW-1:0]     wb_dat_o,
  output logic [WB_DW/8-1:0]   wb_sel_o,
  input  logic [WB_DW-1:0]     wb_dat_i,
  input  logic                 wb_ack_i,
  input  logic [NUM_IRQ-1:0]   irq_src_i,
  output logic                 irq_o
);

  localparam int unsigned SEL_W = WB_DW / 8;
  localparam int unsigned BSH   = $clog2(SEL_W);
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_IRQ-1:0] EDGE_M   = IRQ_EDGE_MASK[NUM_IRQ-1:0];
  localparam logic [31:0]        BAD_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {IDLE, WB_WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic               cyc_q, cyc_d;
  logic               we_q, we_d;
  logic [WB_AW-1:0]   adr_q, adr_d;
  logic [WB_DW-1:0]   dat_q, dat_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        prdata_q, prdata_d;
  logic               pready_q, pready_d;
  logic               pslverr_q, pslverr_d;
  logic [NUM_IRQ-1:0] im_q, im_d;
  logic [NUM_IRQ-1:0] ris_q, ris_d;
  logic [NUM_IRQ-1:0] src_q;
  logic [NUM_IRQ-1:0] icr_clr;
  logic               irq_q;

  // Address bits above the page select and unused write-data bits are dropped.
  logic unused_apb;
  assign unused_apb = ^{apb.paddr[31:16], apb.pwdata};

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      cnt_q     <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      im_q      <= '0;
      ris_q     <= '0;
      src_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      cnt_q     <= cnt_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      im_q      <= im_d;
      ris_q     <= ris_d;
      src_q     <= irq_src_i;
      irq_q     <= |(ris_q & im_q);
    end
  end

  // Transaction FSM: local register actions, Wishbone handshake, response.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    cnt_d     = cnt_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = pslverr_q;
    im_d      = im_q;
    icr_clr   = '0;
    case (state_q)
      IDLE: begin
        if (apb.psel && apb.penable) begin
          if (apb.paddr[15:8] == REG_PAGE) begin
            state_d   = RESP;
            pready_d  = 1'b1;
            pslverr_d = 1'b0;
            // Read data reflects register contents before this edge's write.
            case (apb.paddr[7:0])
              8'h00: begin
                prdata_d = 32'(im_q);
                if (apb.pwrite) im_d = apb.pwdata[NUM_IRQ-1:0];
              end
              8'h04: prdata_d = 32'(ris_q & im_q);
              8'h08: prdata_d = 32'(ris_q);
              8'h0C: begin
                prdata_d = '0;
                if (apb.pwrite) icr_clr = apb.pwdata[NUM_IRQ-1:0] & EDGE_M;
              end
              default: begin
                prdata_d  = BAD_DATA;
                pslverr_d = 1'b1;
              end
            endcase
          end else begin
            state_d = WB_WAIT;
            cyc_d   = 1'b1;
            we_d    = apb.pwrite;
            adr_d   = apb.paddr[WB_AW+BSH-1:BSH];
            dat_d   = apb.pwdata[WB_DW-1:0];
            cnt_d   = '0;
          end
        end
      end
      WB_WAIT: begin
        if (wb_ack_i) begin
          state_d   = RESP;
          cyc_d     = 1'b0;
          prdata_d  = 32'(wb_dat_i);
          pslverr_d = 1'b0;
          pready_d  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = RESP;
          cyc_d     = 1'b0;
          prdata_d  = BAD_DATA;
          pslverr_d = 1'b1;
          pready_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Raw status: level bits follow the source; edge bits stick, set beats clear.
  always_comb begin
    ris_d = irq_src_i;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      if (EDGE_M[i]) ris_d[i] = (irq_src_i[i] & ~src_q[i]) | (ris_q[i] & ~icr_clr[i]);
    end
  end

  assign apb.prdata  = prdata_q;
  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = we_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = '1;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_ef_apb_wb_irq_bridge.sv
// ----------------------------------------------------------------------------
// tb_ef_apb_wb_irq_bridge
// Directed bench for ef_apb_wb_irq_bridge (NUM_IRQ=9, source 1 edge-sticky,
// WB_DW=16, WB_AW=3, REG_PAGE=0x0F, TIMEOUT_CYCLES=8).
// ----------------------------------------------------------------------------
module tb_ef_apb_wb_irq_bridge;

  logic        clk;
  logic        rst;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [2:0]  wb_adr_o;
  logic [15:0] wb_dat_o;
  logic [1:0]  wb_sel_o;
  logic [15:0] wb_dat_i;
  logic        wb_ack_i;
  logic [8:0]  irq_src;
  logic        irq_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Results of the last APB transfer.
  logic [31:0] r_data;
  logic        r_err;
  int          r_lat;
  int          r_ack_lat;
  int          r_cyc;
  int          r_stb;
  logic [2:0]  r_adr;
  logic        r_we;
  logic [15:0] r_dat;
  logic [1:0]  r_sel;
  logic        r_cyc_at_resp;

  ef_apb_wb_irq_bridge_if apb_bus ();

  ef_apb_wb_irq_bridge #(
    .NUM_IRQ       (9),
    .IRQ_EDGE_MASK (32'h0000_0002),
    .WB_DW         (16),
    .WB_AW         (3),
    .REG_PAGE      (8'h0F),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .apb      (apb_bus),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_sel_o (wb_sel_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i),
    .irq_src_i(irq_src),
    .irq_o    (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One APB transfer; pulse is raised on the sources for the first access cycle,
  // ack_after>0 acks on that cycle of cyc (0: never ack).
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [8:0] pulse, input int ack_after, input logic [15:0] ack_data);
    int ack_iter;
    ack_iter = -1;
    r_data = '0; r_err = 1'b0; r_lat = 0; r_ack_lat = -1; r_cyc = 0; r_stb = 0;
    r_adr = '0; r_we = 1'b0; r_dat = '0; r_sel = '0; r_cyc_at_resp = 1'b1;
    @(posedge clk); #1;
    apb_bus.psel = 1'b1; apb_bus.penable = 1'b0; apb_bus.pwrite = wr;
    apb_bus.paddr = addr; apb_bus.pwdata = wdata;
    @(posedge clk); #1;
    apb_bus.penable = 1'b1;
    irq_src = irq_src | pulse;
    for (int it = 1; it <= 60; it++) begin
      @(posedge clk); #1;
      irq_src = irq_src & ~pulse;
      r_lat = it;
      if (apb_bus.pready) begin
        r_data = apb_bus.prdata;
        r_err = apb_bus.pslverr;
        r_cyc_at_resp = wb_cyc_o | wb_stb_o;
        if (ack_iter >= 0) r_ack_lat = it - ack_iter;
        break;
      end
      wb_ack_i = 1'b0;
      if (wb_stb_o) r_stb++;
      if (wb_cyc_o) begin
        r_cyc++;
        if (r_cyc == 1) begin
          r_adr = wb_adr_o; r_we = wb_we_o; r_dat = wb_dat_o; r_sel = wb_sel_o;
        end
        if (ack_after != 0 && r_cyc == ack_after) begin
          wb_ack_i = 1'b1; wb_dat_i = ack_data; ack_iter = it;
        end
      end
    end
    wb_ack_i = 1'b0;
    apb_bus.psel = 1'b0; apb_bus.penable = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    apb_bus.psel = 1'b0; apb_bus.penable = 1'b0; apb_bus.pwrite = 1'b0;
    apb_bus.paddr = '0; apb_bus.pwdata = '0;
    wb_dat_i = '0; wb_ack_i = 1'b0; irq_src = '0;
    tick(3);
    rst = 1'b0;

    // Reset state
    check("rst_pready", 32'(apb_bus.pready), 32'd0);
    check("rst_pslverr", 32'(apb_bus.pslverr), 32'd0);
    check("rst_prdata", apb_bus.prdata, 32'd0);
    check("rst_cyc", 32'(wb_cyc_o), 32'd0);
    check("rst_stb", 32'(wb_stb_o), 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);

    // Local IM write returns pre-write value, then readback
    apb_xfer(1'b1, 32'h0000_0F00, 32'h0000_01FF, 9'h0, 0, 16'h0);
    check("im_wr_lat", 32'(r_lat), 32'd1);
    check("im_wr_prdata", r_data, 32'h0000_0000);
    check("im_wr_err", 32'(r_err), 32'd0);
    apb_xfer(1'b0, 32'h0000_0F00, 32'h0, 9'h0, 0, 16'h0);
    check("im_rd_lat", 32'(r_lat), 32'd1);
    check("im_rd_prdata", r_data, 32'h0000_01FF);
    check("im_rd_err", 32'(r_err), 32'd0);

    // Undefined local offset
    apb_xfer(1'b0, 32'h0000_0F10, 32'h0, 9'h0, 0, 16'h0);
    check("bad_off_prdata", r_data, 32'hDEADBEEF);
    check("bad_off_err", 32'(r_err), 32'd1);

    // Write to read-only MIS: no error, no effect on IM
    apb_xfer(1'b1, 32'h0000_0F04, 32'hFFFF_FFFF, 9'h0, 0, 16'h0);
    check("ro_wr_err", 32'(r_err), 32'd0);
    apb_xfer(1'b0, 32'h0000_0F00, 32'h0, 9'h0, 0, 16'h0);
    check("ro_wr_im", r_data, 32'h0000_01FF);
    apb_xfer(1'b0, 32'h0000_0F0C, 32'h0, 9'h0, 0, 16'h0);
    check("icr_rd", r_data, 32'h0000_0000);

    // Wishbone read, ack on third strobe cycle
    apb_xfer(1'b0, 32'h0000_0004, 32'h0, 9'h0, 3, 16'hBEEF);
    check("wbr_adr", 32'(r_adr), 32'd2);
    check("wbr_we", 32'(r_we), 32'd0);
    check("wbr_sel", 32'(r_sel), 32'h3);
    check("wbr_cyc_cycles", 32'(r_cyc), 32'd3);
    check("wbr_stb_cycles", 32'(r_stb), 32'd3);
    check("wbr_ack_lat", 32'(r_ack_lat), 32'd1);
    check("wbr_cyc_dropped", 32'(r_cyc_at_resp), 32'd0);
    check("wbr_prdata", r_data, 32'h0000_BEEF);
    check("wbr_err", 32'(r_err), 32'd0);
    tick(1);
    check("wbr_pready_fall", 32'(apb_bus.pready), 32'd0);
    check("wbr_prdata_hold", apb_bus.prdata, 32'h0000_BEEF);

    // Wishbone write with no ack: timeout after 8 cycles
    apb_xfer(1'b1, 32'h0000_0002, 32'h1234_5678, 9'h0, 0, 16'h0);
    check("wbw_adr", 32'(r_adr), 32'd1);
    check("wbw_we", 32'(r_we), 32'd1);
    check("wbw_dat", 32'(r_dat), 32'h0000_5678);
    check("wbw_cyc_cycles", 32'(r_cyc), 32'd8);
    check("wbw_cyc_dropped", 32'(r_cyc_at_resp), 32'd0);
    check("wbw_prdata", r_data, 32'hDEADBEEF);
    check("wbw_err", 32'(r_err), 32'd1);
    // Late ack is ignored
    wb_ack_i = 1'b1; wb_dat_i = 16'h1111;
    tick(1);
    check("late_ack_pready0", 32'(apb_bus.pready), 32'd0);
    check("late_ack_cyc0", 32'(wb_cyc_o), 32'd0);
    tick(1);
    check("late_ack_pready1", 32'(apb_bus.pready), 32'd0);
    check("late_ack_prdata", apb_bus.prdata, 32'hDEADBEEF);
    wb_ack_i = 1'b0;

    // Edge source 1 with IM=0x3
    apb_xfer(1'b1, 32'h0000_0F00, 32'h0000_0003, 9'h0, 0, 16'h0);
    check("im3_prev", r_data, 32'h0000_01FF);
    tick(1); irq_src = 9'h002;
    tick(1); irq_src = 9'h000;
    tick(3);
    check("edge_irq", 32'(irq_o), 32'd1);
    apb_xfer(1'b0, 32'h0000_0F08, 32'h0, 9'h0, 0, 16'h0);
    check("edge_ris", r_data, 32'h0000_0002);
    apb_xfer(1'b0, 32'h0000_0F04, 32'h0, 9'h0, 0, 16'h0);
    check("edge_mis", r_data, 32'h0000_0002);
    apb_xfer(1'b1, 32'h0000_0F0C, 32'h0000_0002, 9'h0, 0, 16'h0);
    check("icr_irq_still", 32'(irq_o), 32'd1);
    tick(1);
    check("icr_irq_clear", 32'(irq_o), 32'd0);
    apb_xfer(1'b0, 32'h0000_0F08, 32'h0, 9'h0, 0, 16'h0);
    check("icr_ris", r_data, 32'h0000_0000);

    // Pulse coinciding with the ICR write: set wins
    apb_xfer(1'b1, 32'h0000_0F0C, 32'h0000_0002, 9'h002, 0, 16'h0);
    apb_xfer(1'b0, 32'h0000_0F08, 32'h0, 9'h0, 0, 16'h0);
    check("set_wins_ris", r_data, 32'h0000_0002);
    apb_xfer(1'b1, 32'h0000_0F0C, 32'h0000_0002, 9'h0, 0, 16'h0);
    apb_xfer(1'b0, 32'h0000_0F08, 32'h0, 9'h0, 0, 16'h0);
    check("reclear_ris", r_data, 32'h0000_0000);

    // Level source 0, masked then unmasked
    apb_xfer(1'b1, 32'h0000_0F00, 32'h0000_0002, 9'h0, 0, 16'h0);
    irq_src = 9'h001;
    tick(5);
    apb_xfer(1'b0, 32'h0000_0F08, 32'h0, 9'h0, 0, 16'h0);
    check("lvl_ris", r_data, 32'h0000_0001);
    apb_xfer(1'b0, 32'h0000_0F04, 32'h0, 9'h0, 0, 16'h0);
    check("lvl_mis_masked", r_data, 32'h0000_0000);
    check("lvl_irq_masked", 32'(irq_o), 32'd0);
    apb_xfer(1'b1, 32'h0000_0F0C, 32'h0000_0001, 9'h0, 0, 16'h0);
    apb_xfer(1'b0, 32'h0000_0F08, 32'h0, 9'h0, 0, 16'h0);
    check("lvl_icr_ignored", r_data, 32'h0000_0001);
    apb_xfer(1'b1, 32'h0000_0F00, 32'h0000_0003, 9'h0, 0, 16'h0);
    tick(1);
    check("lvl_irq_on", 32'(irq_o), 32'd1);
    irq_src = 9'h000;
    tick(1);
    check("lvl_irq_fall1", 32'(irq_o), 32'd1);
    tick(1);
    check("lvl_irq_fall2", 32'(irq_o), 32'd0);

    // Reset while waiting on Wishbone
    tick(1);
    apb_bus.psel = 1'b1; apb_bus.penable = 1'b0; apb_bus.pwrite = 1'b0;
    apb_bus.paddr = 32'h0000_0006; apb_bus.pwdata = '0;
    tick(1);
    apb_bus.penable = 1'b1;
    tick(2);
    check("mid_rst_cyc_before", 32'(wb_cyc_o), 32'd1);
    rst = 1'b1;
    tick(1);
    check("mid_rst_cyc", 32'(wb_cyc_o), 32'd0);
    check("mid_rst_stb", 32'(wb_stb_o), 32'd0);
    check("mid_rst_pready", 32'(apb_bus.pready), 32'd0);
    rst = 1'b0;
    apb_bus.psel = 1'b0; apb_bus.penable = 1'b0;
    apb_xfer(1'b0, 32'h0000_0F00, 32'h0, 9'h0, 0, 16'h0);
    check("mid_rst_im", r_data, 32'h0000_0000);
    apb_xfer(1'b0, 32'h0000_0F08, 32'h0, 9'h0, 0, 16'h0);
    check("mid_rst_ris", r_data, 32'h0000_0000);
    apb_xfer(1'b0, 32'h0000_000E, 32'h0, 9'h0, 1, 16'hA5A5);
    check("post_rst_adr", 32'(r_adr), 32'd7);
    check("post_rst_cyc_cycles", 32'(r_cyc), 32'd1);
    check("post_rst_ack_lat", 32'(r_ack_lat), 32'd1);
    check("post_rst_prdata", r_data, 32'h0000_A5A5);
    check("post_rst_err", 32'(r_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
